sound_sequencer: RTL and testbench



---
 rtl/sound_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sound_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Single-speaker sound sequencer: pends one-cycle requests, grants by fixed priority,
// plays a 4-note effect from a built-in table and drives the square wave directly.
module sound_sequencer #(
    parameter logic [23:0] NOTE_CYC  = 24'd1250000,
    parameter int unsigned DIV_SHIFT = 6
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       pause,
    input  logic       stall,
    input  logic [3:0] req,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);
    localparam int unsigned HW = 8 + DIV_SHIFT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nx;
    logic [3:0]    r_pending, w_pending_nx, w_req_set, w_clr;
    logic [1:0]    r_note_idx, w_note_idx_nx;
    logic [23:0]   r_dur_cnt, w_dur_nx;
    logic [HW-1:0] r_half_cnt, w_half_nx;
    logic          r_speaker, w_speaker_nx;
    logic          r_busy, w_busy_nx;
    logic [1:0]    r_active_id, w_active_nx;
    logic          r_done, w_done_nx;
    logic          w_freeze, w_grant;
    logic [1:0]    w_win;
    logic [7:0]    w_code;

    function automatic logic [7:0] note_code(input logic [1:0] id, input logic [1:0] idx);
        case ({id, idx})
            4'h0:    note_code = 8'h40;
            4'h1:    note_code = 8'h30;
            4'h2:    note_code = 8'h00;
            4'h3:    note_code = 8'h00;
            4'h4:    note_code = 8'h20;
            4'h5:    note_code = 8'h28;
            4'h6:    note_code = 8'h30;
            4'h7:    note_code = 8'h38;
            4'h8:    note_code = 8'h10;
            4'h9:    note_code = 8'h18;
            4'hA:    note_code = 8'h20;
            4'hB:    note_code = 8'h10;
            4'hC:    note_code = 8'h50;
            4'hD:    note_code = 8'h60;
            4'hE:    note_code = 8'h70;
            default: note_code = 8'h80;
        endcase
    endfunction

    // Half-period reload; rests park the counter at zero.
    function automatic logic [HW-1:0] half_load(input logic [7:0] code);
        half_load = (code == 8'h00) ? '0 : ((HW'(code) << DIV_SHIFT) - HW'(1));
    endfunction

    assign w_freeze = pause | stall;
    assign w_code   = note_code(r_active_id, r_note_idx);

    always_comb begin
        w_win = 2'd0;
        if (r_pending[3])      w_win = 2'd3;
        else if (r_pending[2]) w_win = 2'd2;
        else if (r_pending[1]) w_win = 2'd1;
    end

    always_comb begin
        w_state_nx    = r_state;
        w_note_idx_nx = r_note_idx;
        w_dur_nx      = r_dur_cnt;
        w_half_nx     = r_half_cnt;
        w_speaker_nx  = r_speaker;
        w_busy_nx     = r_busy;
        w_active_nx   = r_active_id;
        w_done_nx     = 1'b0;
        w_grant       = 1'b0;
        w_clr         = 4'd0;
        w_req_set     = req;
        // A request for the effect already playing neither restarts nor queues it.
        if (r_state == S_PLAY) w_req_set[r_active_id] = 1'b0;

        if (w_freeze) begin
            w_speaker_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != 4'd0) w_grant = 1'b1;
                end
                S_PLAY: begin
                    if (w_win > r_active_id) begin
                        w_grant = 1'b1;
                    end else if (r_dur_cnt == 24'd0) begin
                        w_speaker_nx = 1'b0;
                        if (r_note_idx == 2'd3) begin
                            w_state_nx  = S_DONE;
                            w_busy_nx   = 1'b0;
                            w_active_nx = 2'd0;
                            w_done_nx   = 1'b1;
                        end else begin
                            w_note_idx_nx = r_note_idx + 2'd1;
                            w_dur_nx      = NOTE_CYC - 24'd1;
                            w_half_nx     = half_load(note_code(r_active_id, r_note_idx + 2'd1));
                        end
                    end else begin
                        w_dur_nx = r_dur_cnt - 24'd1;
                        if (w_code != 8'h00) begin
                            if (r_half_cnt == '0) begin
                                w_speaker_nx = ~r_speaker;
                                w_half_nx    = half_load(w_code);
                            end else begin
                                w_half_nx = r_half_cnt - HW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        if (w_grant) begin
            w_state_nx    = S_PLAY;
            w_active_nx   = w_win;
            w_note_idx_nx = 2'd0;
            w_dur_nx      = NOTE_CYC - 24'd1;
            w_half_nx     = half_load(note_code(w_win, 2'd0));
            w_speaker_nx  = 1'b0;
            w_busy_nx     = 1'b1;
            w_clr[w_win]  = 1'b1;
        end
        w_pending_nx = (r_pending & ~w_clr) | w_req_set;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_pending   <= 4'd0;
            r_note_idx  <= 2'd0;
            r_dur_cnt   <= 24'd0;
            r_half_cnt  <= '0;
            r_speaker   <= 1'b0;
            r_busy      <= 1'b0;
            r_active_id <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pending   <= w_pending_nx;
            r_note_idx  <= w_note_idx_nx;
            r_dur_cnt   <= w_dur_nx;
            r_half_cnt  <= w_half_nx;
            r_speaker   <= w_speaker_nx;
            r_busy      <= w_busy_nx;
            r_active_id <= w_active_nx;
            r_done      <= w_done_nx;
        end
    end

    assign speaker   = r_speaker;
    assign busy      = r_busy;
    assign active_id = r_active_id;
    assign done      = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: two instances (short notes, and long notes with a shifted
// divider so the square wave toggles) checked every cycle against a playback-position model.
module tb_sound_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    logic       clk   = 1'b0;
    logic       RST   = 1'b0;
    logic       pause = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] req   = 4'd0;

    logic       spk_a, busy_a, done_a;
    logic [1:0] aid_a;
    logic       spk_b, busy_b, done_b;
    logic [1:0] aid_b;

    sound_sequencer #(.NOTE_CYC(24'd16), .DIV_SHIFT(0)) u_dut_a (
        .clk(clk), .RST(RST), .pause(pause), .stall(stall), .req(req),
        .speaker(spk_a), .busy(busy_a), .active_id(aid_a), .done(done_a)
    );

    sound_sequencer #(.NOTE_CYC(24'd200), .DIV_SHIFT(1)) u_dut_b (
        .clk(clk), .RST(RST), .pause(pause), .stall(stall), .req(req),
        .speaker(spk_b), .busy(busy_b), .active_id(aid_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int codes [4][4] = '{'{'h40, 'h30, 0, 0},
                         '{'h20, 'h28, 'h30, 'h38},
                         '{'h10, 'h18, 'h20, 'h10},
                         '{'h50, 'h60, 'h70, 'h80}};
    int mnc [2] = '{16, 200};
    int msh [2] = '{0, 1};

    // Model: which effect plays and how many unfrozen cycles it has run.
    int       m_mode [2];
    int       m_id   [2];
    int       m_pos  [2];
    int       m_ph   [2];
    bit [3:0] m_pend [2];
    bit       m_busy [2];
    bit       m_done [2];
    bit       m_spk  [2];
    int       m_aid  [2];

    function automatic int half_of(input int c, input int id, input int pos);
        return codes[id][pos / mnc[c]] << msh[c];
    endfunction

    task automatic model_reset(input int c);
        m_mode[c] = M_IDLE; m_id[c] = 0; m_pos[c] = 0; m_ph[c] = 0; m_pend[c] = 4'd0;
        m_busy[c] = 1'b0; m_done[c] = 1'b0; m_spk[c] = 1'b0; m_aid[c] = 0;
    endtask

    task automatic model_step(input int c);
        bit       frz, grant;
        bit [3:0] setb;
        int       win, h;
        frz  = pause | stall;
        setb = req;
        if (m_mode[c] == M_PLAY) setb[m_id[c]] = 1'b0;
        win = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[c][i] && win < 0) win = i;
        grant     = 1'b0;
        m_done[c] = 1'b0;
        if (!frz) begin
            case (m_mode[c])
                M_IDLE: grant = (win >= 0);
                M_PLAY: begin
                    if (win > m_id[c]) grant = 1'b1;
                    else if (m_pos[c] == 4 * mnc[c] - 1) begin
                        m_mode[c] = M_DONE;
                        m_done[c] = 1'b1;
                    end else begin
                        m_pos[c]++;
                        if (m_pos[c] % mnc[c] == 0) m_ph[c] = 0;
                    end
                end
                default: m_mode[c] = M_IDLE;
            endcase
        end else if (m_mode[c] == M_PLAY) begin
            // Speaker restarts low after a freeze, so re-phase the wave at the held position.
            h = half_of(c, m_id[c], m_pos[c]);
            if (h != 0) m_ph[c] = ((m_pos[c] % mnc[c]) / h) % 2;
        end
        if (grant) begin
            m_mode[c] = M_PLAY; m_id[c] = win; m_pos[c] = 0; m_ph[c] = 0;
            m_pend[c][win] = 1'b0;
        end
        m_pend[c] = m_pend[c] | setb;
        m_busy[c] = (m_mode[c] == M_PLAY);
        m_aid[c]  = m_busy[c] ? m_id[c] : 0;
        h = m_busy[c] ? half_of(c, m_id[c], m_pos[c]) : 0;
        m_spk[c] = !frz && m_busy[c] && (h != 0) &&
                   ((((m_pos[c] % mnc[c]) / h) + m_ph[c]) % 2 == 1);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge RST);
            if (!RST) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cmp1(input string nm, input int c, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", nm, c, $time, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp1("speaker",   0, int'(spk_a),  int'(m_spk[0]));
                cmp1("busy",      0, int'(busy_a), int'(m_busy[0]));
                cmp1("active_id", 0, int'(aid_a),  m_aid[0]);
                cmp1("done",      0, int'(done_a), int'(m_done[0]));
                cmp1("speaker",   1, int'(spk_b),  int'(m_spk[1]));
                cmp1("busy",      1, int'(busy_b), int'(m_busy[1]));
                cmp1("active_id", 1, int'(aid_b),  m_aid[1]);
                cmp1("done",      1, int'(done_b), int'(m_done[1]));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int run, k;
        run = 0;
        k   = 0;
        while (run < 3 && k < budget) begin
            @(negedge clk);
            run = (!busy_a && !busy_b) ? run + 1 : 0;
            k++;
        end
        chk("wait_idle_timeout", int'(run >= 3), 1);
    endtask

    // Drives one directed pattern; cycle 0 is the cycle the first request is presented.
    task automatic scenario(input logic [3:0] r0, input int c1, input logic [3:0] r1,
                            input int ps, input int pl, input int rc, input int pc,
                            input int ncyc, output int fb, output int d1, output int d2,
                            output int nd, output int pid, output int lb, output int nbp);
        fb = -1; d1 = -1; d2 = -1; nd = 0; pid = -1; nbp = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            req   = (c == 0) ? r0 : ((c == c1) ? r1 : 4'd0);
            pause = (c >= ps) && (c < ps + pl);
            if (c == rc + 1) RST = 1'b1;
            if (c == rc) begin
                RST = 1'b0;
                #1;
                chk("rst_speaker", int'(spk_a),  0);
                chk("rst_busy",    int'(busy_a), 0);
                chk("rst_done",    int'(done_a), 0);
                chk("rst_active",  int'(aid_a),  0);
            end
            @(negedge clk);
            if (busy_a && fb < 0) fb = c;
            if (busy_a && rc >= 0 && c >= rc) nbp++;
            if (done_a) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == pc) pid = int'(aid_a);
        end
        lb = int'(busy_a);
        @(posedge clk);
        #1;
        req   = 4'd0;
        pause = 1'b0;
    endtask

    initial begin
        int       fb, d1, d2, nd, pid, lb, nbp, plen, psel;
        bit [3:0] r;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_speaker", int'(spk_a),  0);
        chk("reset_busy",    int'(busy_a), 0);
        chk("reset_active",  int'(aid_a),  0);
        chk("reset_done",    int'(done_a), 0);
        RST = 1'b1;
        repeat (2) @(posedge clk);

        // Power effect end to end.
        scenario(4'b0010, -1, 4'd0, -1, 0, -10, 2, 80, fb, d1, d2, nd, pid, lb, nbp);
        chk("power_first_busy", fb, 2);
        chk("power_done_cycle", d1, 66);
        chk("power_done_count", nd, 1);
        chk("power_active_id",  pid, 1);
        wait_idle(4000);

        // Death preempts chomp; chomp is dropped.
        scenario(4'b0001, 5, 4'b1000, -1, 0, -10, 7, 100, fb, d1, d2, nd, pid, lb, nbp);
        chk("preempt_active_id",  pid, 3);
        chk("preempt_done_cycle", d1, 71);
        chk("preempt_done_count", nd, 1);
        chk("preempt_no_replay",  lb, 0);
        wait_idle(4000);

        // Simultaneous ghost + chomp play back to back.
        scenario(4'b0101, -1, 4'd0, -1, 0, -10, 2, 150, fb, d1, d2, nd, pid, lb, nbp);
        chk("dual_first_id",    pid, 2);
        chk("dual_done1_cycle", d1, 66);
        chk("dual_done2_cycle", d2, 132);
        chk("dual_done_count",  nd, 2);
        wait_idle(4000);

        // Pause for 10 cycles stretches the effect by 10.
        scenario(4'b0010, -1, 4'd0, 10, 10, -10, 15, 90, fb, d1, d2, nd, pid, lb, nbp);
        chk("pause_done_cycle", d1, 76);
        chk("pause_done_count", nd, 1);
        chk("pause_active_id",  pid, 1);
        wait_idle(4000);

        // Re-requesting the playing chomp is ignored.
        scenario(4'b0001, 20, 4'b0001, -1, 0, -10, 30, 100, fb, d1, d2, nd, pid, lb, nbp);
        chk("rereq_done_cycle", d1, 66);
        chk("rereq_done_count", nd, 1);
        chk("rereq_active_id",  pid, 0);
        wait_idle(4000);

        // Reset in the middle of a note.
        scenario(4'b0010, -1, 4'd0, -1, 0, 30, 29, 80, fb, d1, d2, nd, pid, lb, nbp);
        chk("rst_first_busy",    fb, 2);
        chk("rst_no_done",       nd, 0);
        chk("rst_silent_after",  nbp, 0);
        chk("rst_active_before", pid, 1);
        wait_idle(4000);

        // Random requests, pause/stall bursts and occasional resets.
        plen = 0;
        psel = 0;
        for (int k = 0; k < 12000; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 349) == 0);
            req = r;
            if (plen == 0 && $urandom_range(0, 149) == 0) begin
                plen = int'($urandom_range(1, 12));
                psel = int'($urandom_range(0, 2));
            end
            pause = (plen > 0) && (psel != 1);
            stall = (plen > 0) && (psel != 0);
            if (plen > 0) plen--;
            if (!RST) RST = 1'b1;
            else if ($urandom_range(0, 3999) == 0) RST = 1'b0;
        end
        @(posedge clk);
        #1;
        req   = 4'd0;
        pause = 1'b0;
        stall = 1'b0;
        RST   = 1'b1;
        wait_idle(4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
